// File: rtl/fp32_pkg.sv
// Shared binary32 types and the two combinational halves of the multiplier datapath.
package fp32_pkg;

  localparam int FP32_BIAS    = 127;
  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam int FP32_EXP_MAX = 255;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp_sum;
    logic [47:0] prod;
    logic        sp_nan;
    logic        sp_inf;
    logic        sp_zero;
  } mul_s1_t;

  typedef struct packed {
    logic [31:0] res;
    fp_flags_t   flags;
  } mul_out_t;

  function automatic fp_class_e fp32_classify(input fp32_t x);
    if (x.exp == 8'd0) return FP_ZERO;
    if (x.exp == 8'hFF) return (x.mant == 23'd0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  function automatic mul_s1_t fp32_mul_stage1(input fp32_t a, input fp32_t b);
    mul_s1_t   s;
    fp_class_e ca;
    fp_class_e cb;
    ca = fp32_classify(a);
    cb = fp32_classify(b);
    s.sign    = a.sign ^ b.sign;
    s.exp_sum = {2'b00, a.exp} + {2'b00, b.exp} - 10'(FP32_BIAS);
    // Hidden bit is always 1 here; zero/denormal operands are overridden by sp_zero.
    s.prod    = {24'd0, 1'b1, a.mant} * {24'd0, 1'b1, b.mant};
    s.sp_nan  = (ca == FP_NAN) || (cb == FP_NAN) ||
                (ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF);
    s.sp_inf  = (ca == FP_INF) || (cb == FP_INF);
    s.sp_zero = (ca == FP_ZERO) || (cb == FP_ZERO);
    return s;
  endfunction

  function automatic mul_out_t fp32_round_pack(input mul_s1_t s);
    mul_out_t           o;
    logic               hi, guard, sticky, inc, carry;
    logic [22:0]        mant_pre, mant_r;
    logic signed [9:0]  exp_n, exp_r;
    o        = '0;
    hi       = s.prod[47];
    mant_pre = hi ? s.prod[46:24] : s.prod[45:23];
    guard    = hi ? s.prod[23] : s.prod[22];
    sticky   = hi ? |s.prod[22:0] : |s.prod[21:0];
    inc      = guard & (sticky | mant_pre[0]);
    {carry, mant_r} = {1'b0, mant_pre} + {23'd0, inc};
    exp_n    = $signed(s.exp_sum) + $signed({9'd0, hi});
    exp_r    = exp_n + $signed({9'd0, carry});
    if (s.sp_nan) begin
      o.res           = FP32_QNAN;
      o.flags.invalid = 1'b1;
    end else if (s.sp_inf) begin
      o.res = {s.sign, 8'hFF, 23'd0};
    end else if (s.sp_zero) begin
      o.res = {s.sign, 31'd0};
    end else if (int'(exp_n) <= 0) begin
      // Underflow is judged before rounding; no denormal is ever produced.
      o.res             = {s.sign, 31'd0};
      o.flags.underflow = 1'b1;
      o.flags.inexact   = 1'b1;
    end else if (int'(exp_r) >= FP32_EXP_MAX) begin
      o.res            = {s.sign, 8'hFF, 23'd0};
      o.flags.overflow = 1'b1;
      o.flags.inexact  = 1'b1;
    end else begin
      o.res           = {s.sign, exp_r[7:0], mant_r};
      o.flags.inexact = guard | sticky;
    end
    return o;
  endfunction

endpackage

// File: rtl/fp32_mul_lane.sv
// One multiplier lane: stage-1 register (LATENCY>1), round/pack, then delay stages.
module fp32_mul_lane
  import fp32_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        adv_i,
  input  logic        valid_last_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o,
  output fp_flags_t   flags_o
);

  localparam int NR = (LATENCY == 1) ? 1 : LATENCY - 1;

  mul_s1_t  s1_d;
  mul_out_t stage2_d;

  assign s1_d = fp32_mul_stage1(a_i, b_i);

  if (LATENCY == 1) begin : g_single
    assign stage2_d = fp32_round_pack(s1_d);
  end else begin : g_split
    mul_s1_t s1_q;
    always_ff @(posedge clk) begin
      if (!resetn)    s1_q <= '0;
      else if (adv_i) s1_q <= s1_d;
    end
    assign stage2_d = fp32_round_pack(s1_q);
  end

  // The last stage only loads on valid data so res/flags hold across bubbles.
  for (genvar gi = 0; gi < NR; gi++) begin : g_stage
    mul_out_t stage_in;
    mul_out_t stage_q;
    logic     en;
    if (gi == 0) begin : g_first
      assign stage_in = stage2_d;
    end else begin : g_next
      assign stage_in = g_stage[gi-1].stage_q;
    end
    assign en = (gi == NR - 1) ? (adv_i & valid_last_i) : adv_i;
    always_ff @(posedge clk) begin
      if (!resetn)  stage_q <= '0;
      else if (en)  stage_q <= stage_in;
    end
  end

  assign res_o   = g_stage[NR-1].stage_q.res;
  assign flags_o = g_stage[NR-1].stage_q.flags;

endmodule

// File: rtl/fp32_mul_pipe.sv
// NUM_LANES binary32 multipliers sharing one valid chain and a global stall.
module fp32_mul_pipe
  import fp32_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   stall,
  input  logic                   input_valid,
  input  logic [32*NUM_LANES-1:0] A,
  input  logic [32*NUM_LANES-1:0] B,
  output logic [32*NUM_LANES-1:0] res,
  output logic                   output_valid,
  output logic [NUM_LANES-1:0]   flag_invalid,
  output logic [NUM_LANES-1:0]   flag_overflow,
  output logic [NUM_LANES-1:0]   flag_underflow,
  output logic [NUM_LANES-1:0]   flag_inexact
);

  logic               adv;
  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;

  assign adv = ~stall;

  if (LATENCY == 1) begin : g_vd1
    assign valid_d = input_valid;
  end else begin : g_vdn
    assign valid_d = {valid_q[LATENCY-2:0], input_valid};
  end

  always_ff @(posedge clk) begin
    if (!resetn)  valid_q <= '0;
    else if (adv) valid_q <= valid_d;
  end

  assign output_valid = valid_q[LATENCY-1];

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    fp_flags_t lane_flags;
    fp32_mul_lane #(.LATENCY(LATENCY)) u_lane (
      .clk          (clk),
      .resetn       (resetn),
      .adv_i        (adv),
      .valid_last_i (valid_d[LATENCY-1]),
      .a_i          (A[32*gi +: 32]),
      .b_i          (B[32*gi +: 32]),
      .res_o        (res[32*gi +: 32]),
      .flags_o      (lane_flags)
    );
    assign flag_invalid[gi]   = lane_flags.invalid;
    assign flag_overflow[gi]  = lane_flags.overflow;
    assign flag_underflow[gi] = lane_flags.underflow;
    assign flag_inexact[gi]   = lane_flags.inexact;
  end

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Directed bench: single-lane LATENCY=2 instance plus 4-lane instances at LATENCY 1/3/4.
module tb_fp32_mul_pipe;

  // Hand-computed vectors; flags packed {invalid, overflow, underflow, inexact}.
  localparam logic [31:0] T_A [16] = '{
    32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h7F800000,
    32'hFF800000, 32'h7F000000, 32'h80000001, 32'h00800000,
    32'h40400000, 32'hC0400000, 32'h3F000000, 32'h7FC00000,
    32'hFF000000, 32'h3FFFFFFF, 32'h3F800001, 32'h00000000};
  localparam logic [31:0] T_B [16] = '{
    32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h00000000,
    32'h40000000, 32'h7F000000, 32'h3F800000, 32'h00800000,
    32'h40400000, 32'h40000000, 32'h3E800000, 32'h3F800000,
    32'h7F000000, 32'h3FFFFFFF, 32'h3F7FFFFF, 32'hFF800000};
  localparam logic [31:0] T_R [16] = '{
    32'h40400000, 32'h3FC00002, 32'h3F800002, 32'h7FC00000,
    32'hFF800000, 32'h7F800000, 32'h80000000, 32'h00000000,
    32'h41100000, 32'hC0C00000, 32'h3E000000, 32'h7FC00000,
    32'hFF800000, 32'h407FFFFE, 32'h3F800000, 32'h7FC00000};
  localparam logic [3:0] T_F [16] = '{
    4'b0000, 4'b0001, 4'b0001, 4'b1000,
    4'b0000, 4'b0101, 4'b0000, 4'b0011,
    4'b0000, 4'b0000, 4'b0000, 4'b1000,
    4'b0101, 4'b0001, 4'b0001, 4'b1000};

  logic        clk = 1'b0;
  logic        resetn, stall, input_valid;
  logic [31:0] A, B, res;
  logic        output_valid;
  logic [0:0]  f_inv, f_ovf, f_unf, f_inx;

  logic         sw_valid;
  logic [127:0] sw_a, sw_b;
  logic [127:0] sw_res [3];
  logic         sw_ov  [3];
  logic [3:0]   sw_inv [3], sw_ovf [3], sw_unf [3], sw_inx [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fp32_mul_pipe #(.NUM_LANES(1), .LATENCY(2)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .input_valid(input_valid),
    .A(A), .B(B), .res(res), .output_valid(output_valid),
    .flag_invalid(f_inv), .flag_overflow(f_ovf),
    .flag_underflow(f_unf), .flag_inexact(f_inx));

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
    fp32_mul_pipe #(.NUM_LANES(4), .LATENCY(LAT)) u_sw (
      .clk(clk), .resetn(resetn), .stall(stall), .input_valid(sw_valid),
      .A(sw_a), .B(sw_b), .res(sw_res[gi]), .output_valid(sw_ov[gi]),
      .flag_invalid(sw_inv[gi]), .flag_overflow(sw_ovf[gi]),
      .flag_underflow(sw_unf[gi]), .flag_inexact(sw_inx[gi]));
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated operation on the LATENCY=2 instance, including the bubble after it.
  task automatic run1(input int k);
    A = T_A[k];
    B = T_B[k];
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    check($sformatf("v%0d_early_valid", k), 64'(output_valid), 64'd0);
    tick();
    check($sformatf("v%0d_valid", k), 64'(output_valid), 64'd1);
    check($sformatf("v%0d_res", k), 64'(res), 64'(T_R[k]));
    check($sformatf("v%0d_flags", k), 64'({f_inv, f_ovf, f_unf, f_inx}), 64'(T_F[k]));
    tick();
    check($sformatf("v%0d_valid_drop", k), 64'(output_valid), 64'd0);
    check($sformatf("v%0d_res_hold", k), 64'(res), 64'(T_R[k]));
  endtask

  initial begin
    int          in_idx, out_idx, idx;
    logic [31:0] prev_res;
    logic        prev_ov;
    int          cnt [3];
    int          first [3];

    resetn = 1'b0; stall = 1'b0; input_valid = 1'b0; A = '0; B = '0;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0;
    repeat (2) tick();
    check("rst_valid", 64'(output_valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_flags", 64'({f_inv, f_ovf, f_unf, f_inx}), 64'd0);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_sw%0d_valid", g), 64'(sw_ov[g]), 64'd0);
      check($sformatf("rst_sw%0d_res", g), sw_res[g][63:0], 64'd0);
    end
    resetn = 1'b1;
    tick();

    for (int k = 0; k < 8; k++) run1(k);

    // Streaming: 8 back-to-back inputs of 2^k * 3, stall held for 3 cycles.
    in_idx = 0;
    out_idx = 0;
    B = 32'h40400000;
    for (int c = 0; c < 30; c++) begin
      stall = (c >= 4 && c < 7);
      input_valid = (in_idx < 8);
      A = 32'h3F800000 + (32'(in_idx) << 23);
      prev_res = res;
      prev_ov = output_valid;
      tick();
      if (stall) begin
        check($sformatf("stall_c%0d_res", c), 64'(res), 64'(prev_res));
        check($sformatf("stall_c%0d_valid", c), 64'(output_valid), 64'(prev_ov));
      end else begin
        if (input_valid) in_idx++;
        if (output_valid) begin
          check($sformatf("stream_%0d", out_idx), 64'(res),
                64'(32'h40400000 + (32'(out_idx) << 23)));
          out_idx++;
        end
      end
    end
    stall = 1'b0;
    input_valid = 1'b0;
    check("stream_count", 64'(out_idx), 64'd8);

    // Reset while an operation is in flight: it must never emerge.
    A = T_A[8]; B = T_B[8]; input_valid = 1'b1;
    tick();
    A = T_A[9]; B = T_B[9]; resetn = 1'b0;
    tick();
    resetn = 1'b1;
    input_valid = 1'b0;
    check("midrst_valid", 64'(output_valid), 64'd0);
    check("midrst_res", 64'(res), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("midrst_stale_%0d", c), 64'(output_valid), 64'd0);
    end
    run1(10);

    // Four-lane sweep: every table entry appears in exactly one lane slot.
    for (int g = 0; g < 3; g++) begin
      cnt[g] = 0;
      first[g] = -1;
    end
    for (int c = 0; c < 12; c++) begin
      sw_valid = (c < 4);
      for (int l = 0; l < 4; l++) begin
        idx = (4 * c + 5 * l) % 16;
        sw_a[32*l +: 32] = T_A[idx];
        sw_b[32*l +: 32] = T_B[idx];
      end
      tick();
      for (int g = 0; g < 3; g++) begin
        if (sw_ov[g]) begin
          if (first[g] < 0) first[g] = c;
          if (cnt[g] < 4) begin
            for (int l = 0; l < 4; l++) begin
              idx = (4 * cnt[g] + 5 * l) % 16;
              check($sformatf("sweep_L%0d_v%0d_lane%0d", lat_of(g), cnt[g], l),
                    64'({sw_res[g][32*l +: 32], sw_inv[g][l], sw_ovf[g][l], sw_unf[g][l], sw_inx[g][l]}),
                    64'({T_R[idx], T_F[idx]}));
            end
          end
          cnt[g]++;
        end
      end
    end
    sw_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("sweep_L%0d_count", lat_of(g)), 64'(cnt[g]), 64'd4);
      check($sformatf("sweep_L%0d_latency", lat_of(g)), 64'(first[g]), 64'(lat_of(g) - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
